// File: rtl/bsg_manycore_link_sif_tieoff_responder.sv
// Tie-off for an unused manycore link edge: sinks forward packets and queues a credit or
// fill-data return for each, absorbs stray returns, and keeps saturating traffic counters.
module bsg_manycore_link_sif_tieoff_responder #(
  parameter int unsigned             addr_width_p      = 32,
  parameter int unsigned             data_width_p      = 32,
  parameter int unsigned             x_cord_width_p    = 4,
  parameter int unsigned             y_cord_width_p    = 4,
  parameter int unsigned             fifo_els_p        = 2,
  parameter bit                      respond_p         = 1'b1,
  parameter logic [data_width_p-1:0] load_fill_data_p  = '0,
  parameter int unsigned             count_width_p     = 16,
  parameter bit                      warn_on_traffic_p = 1'b1,
  localparam int unsigned fwd_pkt_width_lp  = addr_width_p + 7 + data_width_p
                                              + 2 * (x_cord_width_p + y_cord_width_p),
  localparam int unsigned ret_pkt_width_lp  = 7 + data_width_p + x_cord_width_p
                                              + y_cord_width_p,
  localparam int unsigned link_sif_width_lp = fwd_pkt_width_lp + ret_pkt_width_lp + 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [link_sif_width_lp-1:0] link_sif_i,
  output logic [link_sif_width_lp-1:0] link_sif_o,
  output logic [count_width_p-1:0]     fwd_count_o,
  output logic [count_width_p-1:0]     rev_count_o,
  output logic                         err_o,
  output logic [x_cord_width_p-1:0]    first_src_x_o,
  output logic [y_cord_width_p-1:0]    first_src_y_o
);

  localparam logic [1:0] eOpLoad            = 2'd1;
  localparam logic [1:0] ePacketType_credit = 2'd0;
  localparam logic [1:0] ePacketType_data   = 2'd1;

  localparam int unsigned ptr_w_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int unsigned occ_w_lp = $clog2(fifo_els_p + 1);

  typedef struct packed {
    logic [addr_width_p-1:0]   addr;
    logic [1:0]                op;
    logic [4:0]                reg_id;
    logic [data_width_p-1:0]   payload;
    logic [y_cord_width_p-1:0] src_y_cord;
    logic [x_cord_width_p-1:0] src_x_cord;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } fwd_pkt_t;

  typedef struct packed {
    logic [1:0]                pkt_type;
    logic [data_width_p-1:0]   data;
    logic [4:0]                reg_id;
    logic [y_cord_width_p-1:0] y_cord;
    logic [x_cord_width_p-1:0] x_cord;
  } ret_pkt_t;

  typedef struct packed {
    logic     v;
    fwd_pkt_t data;
    logic     ready_and_rev;
  } fwd_ch_t;

  typedef struct packed {
    logic     v;
    ret_pkt_t data;
    logic     ready_and_rev;
  } rev_ch_t;

  typedef struct packed {
    fwd_ch_t fwd;
    rev_ch_t rev;
  } link_sif_t;

  link_sif_t w_in;
  link_sif_t w_out;
  ret_pkt_t  w_ret;
  logic      w_full;
  logic      w_empty;
  logic      w_fwd_ready;
  logic      w_fwd_acc;
  logic      w_rev_abs;
  logic      w_enq;
  logic      w_deq;
  logic      w_rev_v;
  logic      w_unused;

  ret_pkt_t                  r_mem [fifo_els_p];
  logic [ptr_w_lp-1:0]       r_rd_ptr;
  logic [ptr_w_lp-1:0]       r_wr_ptr;
  logic [occ_w_lp-1:0]       r_occ;
  logic [count_width_p-1:0]  r_fwd_count;
  logic [count_width_p-1:0]  r_rev_count;
  logic                      r_err;
  logic                      r_first_vld;
  logic [x_cord_width_p-1:0] r_first_x;
  logic [y_cord_width_p-1:0] r_first_y;

  assign w_in    = link_sif_i;
  assign w_full  = (r_occ == occ_w_lp'(fifo_els_p));
  assign w_empty = (r_occ == '0);

  // Ready looks at full only, so a same-cycle dequeue never reopens it.
  assign w_fwd_ready = ~reset_i & (~w_full | ~respond_p);
  assign w_fwd_acc   = w_in.fwd.v & w_fwd_ready;
  assign w_enq       = w_fwd_acc & respond_p;
  assign w_rev_v     = respond_p & ~reset_i & ~w_empty;
  assign w_deq       = w_rev_v & w_in.rev.ready_and_rev;
  assign w_rev_abs   = w_in.rev.v & ~reset_i;

  always_comb begin
    w_ret        = '0;
    w_ret.x_cord = w_in.fwd.data.src_x_cord;
    w_ret.y_cord = w_in.fwd.data.src_y_cord;
    w_ret.reg_id = w_in.fwd.data.reg_id;
    if (w_in.fwd.data.op == eOpLoad) begin
      w_ret.pkt_type = ePacketType_data;
      w_ret.data     = load_fill_data_p;
    end else begin
      w_ret.pkt_type = ePacketType_credit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= w_ret;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= (r_wr_ptr == ptr_w_lp'(fifo_els_p - 1)) ? '0 : r_wr_ptr + ptr_w_lp'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == ptr_w_lp'(fifo_els_p - 1)) ? '0 : r_rd_ptr + ptr_w_lp'(1);
      end
      if (w_enq && !w_deq) begin
        r_occ <= r_occ + occ_w_lp'(1);
      end else if (!w_enq && w_deq) begin
        r_occ <= r_occ - occ_w_lp'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_fwd_count <= '0;
      r_rev_count <= '0;
      r_err       <= 1'b0;
      r_first_vld <= 1'b0;
      r_first_x   <= '0;
      r_first_y   <= '0;
    end else begin
      if (w_fwd_acc && (r_fwd_count != '1)) begin
        r_fwd_count <= r_fwd_count + count_width_p'(1);
      end
      if (w_rev_abs && (r_rev_count != '1)) begin
        r_rev_count <= r_rev_count + count_width_p'(1);
      end
      if (w_fwd_acc || w_rev_abs) begin
        r_err <= 1'b1;
      end
      if (w_fwd_acc && !r_first_vld) begin
        r_first_vld <= 1'b1;
        r_first_x   <= w_in.fwd.data.src_x_cord;
        r_first_y   <= w_in.fwd.data.src_y_cord;
      end
    end
  end

  always_comb begin
    w_out                   = '0;
    w_out.fwd.ready_and_rev = w_fwd_ready;
    w_out.rev.v             = w_rev_v;
    w_out.rev.data          = r_mem[r_rd_ptr];
    w_out.rev.ready_and_rev = 1'b1;
  end

  assign link_sif_o    = w_out;
  assign fwd_count_o   = r_fwd_count;
  assign rev_count_o   = r_rev_count;
  assign err_o         = r_err;
  assign first_src_x_o = r_first_x;
  assign first_src_y_o = r_first_y;

  // Fields of the incoming link that a tie-off has no use for.
  assign w_unused = ^{w_in.fwd.ready_and_rev, w_in.fwd.data.addr, w_in.fwd.data.payload,
                      w_in.fwd.data.y_cord, w_in.fwd.data.x_cord, w_in.rev.data};

  if (warn_on_traffic_p) begin : g_warn
    always @(negedge clk_i) begin
      if (!reset_i && w_in.fwd.v) begin
        $error("%m: fwd packet on tied-off link from x=%0d y=%0d",
               w_in.fwd.data.src_x_cord, w_in.fwd.data.src_y_cord);
      end
      if (!reset_i && w_in.rev.v) begin
        $error("%m: return packet on tied-off link");
      end
    end
  end

endmodule
